// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART <-> ALU glue block: state encodings,
// default widths and the ALU opcodes used to exercise it.
package uart_alu_interface_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_COMPUTE = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;

endpackage

// File: rtl/uart_alu_interface_edge_detect_rise.sv
// Single-bit rising-edge detector. A level already high when reset releases
// is ignored until the input has been seen low at least once.
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;
  logic armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= din;
      armed <= armed | ~din;
    end
  end

  assign rise = din & ~prev & armed;

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B and opcode bytes from uart_rx, feeds the ALU and hands the
// result to uart_tx. Optional inter-byte timeout: define UART_IF_TIMEOUT_EN.
module uart_alu_interface
  import uart_alu_interface_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_Clock,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic [2:0]         o_state
);

  // Handshake: a byte (or tx completion) is accepted only on the 0->1 edge of
  // its strobe; holding the strobe high never yields a second event.
  // o_tx_start is a single-cycle request, o_tx_data is stable from the cycle
  // before it until the next result is loaded.
  logic rx_ev;
  logic tx_ev;
  logic timeout;

  state_t state;
  state_t state_next;

  logic [NB_DATA-1:0] a_d;
  logic [NB_DATA-1:0] b_d;
  logic [NB_OP-1:0]   op_d;
  logic [NB_DATA-1:0] tx_data_d;
  logic               tx_start_d;
  logic               busy_d;

  edge_detect_rise u_rx_edge (
    .clk  (i_Clock),
    .rst  (i_reset),
    .din  (i_rx_done),
    .rise (rx_ev)
  );

  edge_detect_rise u_tx_edge (
    .clk  (i_Clock),
    .rst  (i_reset),
    .din  (i_tx_done),
    .rise (tx_ev)
  );

`ifdef UART_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt;
  logic             waiting;

  assign waiting = (state == S_WAIT_B) || (state == S_WAIT_OP);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = waiting && !rx_ev && (idle_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge i_Clock) begin
    if (i_reset || !waiting || rx_ev || timeout)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + CNT_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      state      <= S_WAIT_A;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_next;
      o_data_a   <= a_d;
      o_data_b   <= b_d;
      o_op       <= op_d;
      o_tx_data  <= tx_data_d;
      o_tx_start <= tx_start_d;
      o_busy     <= busy_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_WAIT_A:  if (rx_ev) state_next = S_WAIT_B;
      S_WAIT_B:  if (rx_ev) state_next = S_WAIT_OP;
                 else if (timeout) state_next = S_WAIT_A;
      S_WAIT_OP: if (rx_ev) state_next = S_COMPUTE;
                 else if (timeout) state_next = S_WAIT_A;
      S_COMPUTE: state_next = S_SEND;
      S_SEND:    state_next = S_WAIT_TX;
      S_WAIT_TX: if (tx_ev) state_next = S_WAIT_A;
      default:   state_next = S_WAIT_A;
    endcase
  end

  always_comb begin
    a_d        = o_data_a;
    b_d        = o_data_b;
    op_d       = o_op;
    tx_data_d  = o_tx_data;
    tx_start_d = 1'b0;
    busy_d     = o_busy;
    case (state)
      S_WAIT_A: if (rx_ev) a_d = i_rx_data;
      S_WAIT_B, S_WAIT_OP: begin
        if (rx_ev) begin
          if (state == S_WAIT_B) begin
            b_d = i_rx_data;
          end else begin
            op_d   = i_rx_data[NB_OP-1:0];
            busy_d = 1'b1;
          end
        end else if (timeout) begin
          a_d  = '0;
          b_d  = '0;
          op_d = '0;
        end
      end
      // One cycle for the combinational ALU to settle on the new operands.
      S_COMPUTE: tx_data_d = i_alu_result;
      S_SEND:    tx_start_d = 1'b1;
      S_WAIT_TX: if (tx_ev) busy_d = 1'b0;
      default: ;
    endcase
  end

  assign o_state = state;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed + randomized bench for uart_alu_interface with an ALU model and a
// result scoreboard. Timeout checks depend on UART_IF_TIMEOUT_EN.
module tb_uart_alu_interface;
  import uart_alu_interface_pkg::*;

  logic       clk;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [7:0] alu_result;
  logic       tx_done;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [5:0] op;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_alu_interface #(.TIMEOUT_CYCLES(50)) dut (
    .i_Clock      (clk),
    .i_reset      (reset),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .i_alu_result (alu_result),
    .i_tx_done    (tx_done),
    .o_data_a     (data_a),
    .o_data_b     (data_b),
    .o_op         (op),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .o_busy       (busy),
    .o_state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] opc);
    case (opc)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = alu_model(data_a, data_b, op);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks (called and returning at a falling edge)
  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, data_a, 0);
    check({tag, "_b"}, data_b, 0);
    check({tag, "_op"}, op, 0);
    check({tag, "_txd"}, tx_data, 0);
    check({tag, "_start"}, tx_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, state, S_WAIT_A);
  endtask

  // mode 0: plain, 1: stray byte while waiting for tx, 2: rx and tx events together
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input int hold, input int tx_delay, input int mode);
    int lat;
    logic [5:0] exp_op;
    exp_op = opb[5:0];
    exp_q.push_back(alu_model(a, b, exp_op));
    send_byte(a, hold);
    check("state_b", state, S_WAIT_B);
    send_byte(b, hold);
    check("opnd_a", data_a, a);
    check("opnd_b", data_b, b);
    rx_data = opb;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    check("opcode", op, exp_op);
    check("busy_set", busy, 1);
    lat = 0;
    while (!tx_start && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("start_latency", lat, 2);
    check("tx_data", tx_data, exp_q.pop_front());
    @(negedge clk);
    check("start_one_cycle", tx_start, 0);
    repeat (tx_delay) @(negedge clk);
    if (mode == 1) begin
      send_byte(8'h77, 1);
      check("drop_state", state, S_WAIT_TX);
      check("drop_a", data_a, a);
      check("drop_b", data_b, b);
      check("drop_op", op, exp_op);
    end
    check("busy_hold", busy, 1);
    if (mode == 2) begin
      rx_data = 8'h99;
      rx_done = 1'b1;
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    rx_done = 1'b0;
    check("busy_clear", busy, 0);
    check("state_idle", state, S_WAIT_A);
    check("hold_a", data_a, a);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] ops [3];
    ops[0] = ALU_ADD;
    ops[1] = ALU_SUB;
    ops[2] = ALU_AND;
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // basic ADD, 20 cycles until tx completes
    run_txn(8'h05, 8'h03, 8'h20, 1, 20, 0);

    // long strobe on A counts once
    send_byte(8'hAA, 5);
    check("long_state", state, S_WAIT_B);
    check("long_a", data_a, 8'hAA);
    send_byte(8'h0F, 1);
    send_byte(8'h24, 1);
    check("long_op", op, 6'h24);
    check("long_busy", busy, 1);
    repeat (4) @(negedge clk);
    check("long_txd", tx_data, alu_model(8'hAA, 8'h0F, ALU_AND));
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    check("long_idle", state, S_WAIT_A);

    // drop while busy, then next transaction
    run_txn(8'h31, 8'h42, 8'h20, 1, 5, 1);
    run_txn(8'h01, 8'h02, 8'h22, 1, 3, 0);

    // simultaneous rx/tx event in WAIT_TX: tx honoured, byte dropped
    run_txn(8'h50, 8'h10, 8'h22, 2, 4, 2);
    check("simul_a_kept", data_a, 8'h50);

    // reset mid-operation
    send_byte(8'h10, 1);
    send_byte(8'h20, 1);
    check("mid_state", state, S_WAIT_OP);
    pulse_reset();
    check_all_zero("mid_reset");
    run_txn(8'h09, 8'h04, 8'h22, 1, 2, 0);

    // opcode masking
    run_txn(8'h80, 8'h01, 8'hE2, 1, 2, 0);

    // strobe high through reset release is not an event
    rx_data = 8'h5A;
    rx_done = 1'b1;
    pulse_reset();
    repeat (3) @(negedge clk);
    check("stuck_state", state, S_WAIT_A);
    check("stuck_a", data_a, 0);
    rx_done = 1'b0;
    @(negedge clk);

    // inter-byte silence
    send_byte(8'h33, 1);
    repeat (60) @(negedge clk);
`ifdef UART_IF_TIMEOUT_EN
    check("timeout_state", state, S_WAIT_A);
    check("timeout_a", data_a, 0);
    send_byte(8'h44, 1);
    check("after_timeout_a", data_a, 8'h44);
    send_byte(8'h01, 1);
    send_byte({2'b00, ALU_ADD}, 1);
    repeat (4) @(negedge clk);
    check("after_timeout_txd", tx_data, 8'h45);
`else
    check("notimeout_state", state, S_WAIT_B);
    check("notimeout_a", data_a, 8'h33);
    send_byte(8'h01, 1);
    send_byte({2'b00, ALU_ADD}, 1);
    repeat (4) @(negedge clk);
    check("notimeout_txd", tx_data, 8'h34);
`endif
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);

    // randomized transactions
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [7:0] ropb;
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      ropb = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 2)]};
      run_txn(ra, rb, ropb, $urandom_range(1, 3), $urandom_range(1, 30),
              $urandom_range(0, 2));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Consumes bytes produced by the UART receiver (`o_Rx_Byte` / `o_Rx_Done`) and assembles them into an ALU transaction: operand A, operand B, then opcode.
- Presents the operands and opcode to the combinational ALU and captures its result.
- Hands the result to the UART transmitter with a start/done handshake.
- Sits between uart_rx, the ALU and uart_tx in the TP2 top level.

Parameters:
- NB_DATA, 8, width of operands, result and UART byte.
- NB_OP, 6, width of ALU opcode; taken from the low NB_OP bits of the opcode byte.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in i_Clock cycles. Used only with UART_IF_TIMEOUT_EN.

Ports:
- i_Clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_done  in  1  byte-valid strobe from uart_rx; may be high for more than one cycle.
- i_rx_data  in  NB_DATA  received byte from uart_rx.
- i_alu_result  in  NB_DATA  combinational ALU result.
- i_tx_done  in  1  transmit-complete strobe from uart_tx.
- o_data_a  out  NB_DATA  registered operand A to ALU.
- o_data_b  out  NB_DATA  registered operand B to ALU.
- o_op  out  NB_OP  registered opcode to ALU.
- o_tx_start  out  1  one-cycle pulse requesting transmission.
- o_tx_data  out  NB_DATA  registered byte to uart_tx.
- o_busy  out  1  high from opcode capture until tx done is seen.

Behaviour:
- Reset: clock i_Clock; reset i_reset, synchronous, active-high. It is checked every cycle, including mid-transaction, and takes priority over everything. Effects:
  - State goes to S_WAIT_A.
  - All outputs and the edge-detect registers go to 0.
  - Any partially collected operands are discarded.
- Edge detection:
  - i_rx_done and i_tx_done are each registered once.
  - An event is a 0->1 transition (current=1, previous=0).
  - A level held for N cycles counts as one event.
  - A strobe already high when reset releases is not an event.
- States and transitions:
  - S_WAIT_A: on rx event, o_data_a <= i_rx_data, go to S_WAIT_B.
  - S_WAIT_B: on rx event, o_data_b <= i_rx_data, go to S_WAIT_OP.
  - S_WAIT_OP: on rx event, o_op <= i_rx_data[NB_OP-1:0], o_busy <= 1, go to S_COMPUTE.
  - S_COMPUTE: exactly one cycle, for ALU settle. o_tx_data <= i_alu_result, go to S_SEND.
  - S_SEND: exactly one cycle. o_tx_start <= 1, go to S_WAIT_TX.
  - S_WAIT_TX: o_tx_start <= 0. On tx event, o_busy <= 0, go to S_WAIT_A.
  - Undefined state encodings go to S_WAIT_A.
- Latency: o_tx_start is high in the 3rd cycle after the cycle in which the opcode rx event is detected; o_tx_data is valid one cycle earlier.
- Bytes outside collection states:
  - rx events in S_COMPUTE, S_SEND and S_WAIT_TX are dropped, with no state or operand change.
  - Operand outputs hold their values until overwritten by the next transaction.
- Simultaneous events: an rx event and a tx event in the same S_WAIT_TX cycle. The tx event is honoured and the rx byte is dropped.
- Widths: opcode bits above NB_OP are ignored. No arithmetic is performed here.

Optional Feature:
- Macro: UART_IF_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs while in S_WAIT_B or S_WAIT_OP.
  - It clears on every rx event and on entry to those states.
  - When it reaches TIMEOUT_CYCLES, state returns to S_WAIT_A, o_data_a/o_data_b/o_op clear to 0, and the counter clears.
  - An rx event in the same cycle as the timeout wins: the byte is captured and no timeout occurs.
- Undefined: no counter; the block waits indefinitely between bytes.

Decomposition:
- Shared package/header holds:
  - State encodings: S_WAIT_A=3'd0, S_WAIT_B=3'd1, S_WAIT_OP=3'd2, S_COMPUTE=3'd3, S_SEND=3'd4, S_WAIT_TX=3'd5.
  - Default NB_DATA/NB_OP.
  - ALU opcode constants used by the bench: ADD=6'b100000, SUB=6'b100010, AND=6'b100100.
- One sub-module, edge_detect_rise: single-bit rising-edge detector with synchronous reset, instantiated twice (rx, tx).

Test Plan:
- Basic ADD:
  - Stimulus: rx bytes 0x05, 0x03, 0x20; ALU model returns 0x08; tx_done pulse 20 cycles after start.
  - Response: o_data_a=0x05, o_data_b=0x03, o_op=0x20; o_tx_data=0x08; o_tx_start high exactly 1 cycle, 3 cycles after opcode event; o_busy low after tx_done.
- Long strobe:
  - Stimulus: i_rx_done held high 5 cycles with 0xAA, then bytes 0x0F, 0x24.
  - Response: A=0xAA, B=0x0F, op=0x24; exactly one transaction.
- Drop while busy:
  - Stimulus: send 0x77 during S_WAIT_TX.
  - Response: operands unchanged; after tx_done, next bytes 0x01, 0x02, 0x22 produce A=0x01.
- Reset mid-operation:
  - Stimulus: i_reset for 1 cycle after A=0x10, B=0x20 captured; then bytes 0x09, 0x04, 0x22.
  - Response: all outputs 0 after reset; new transaction A=0x09, B=0x04.
- Opcode masking:
  - Stimulus: opcode byte 0xE2.
  - Response: o_op=6'b100010.
- Timeout (UART_IF_TIMEOUT_EN, TIMEOUT_CYCLES=50):
  - Stimulus: A=0x33, then silence for 50 cycles.
  - Response: state back to S_WAIT_A, o_data_a=0; next byte 0x44 lands in A.
